// File: rtl/spirose_pkg.sv
// Shared types for the slice scheduler.
//   fetch_state_e : fetch engine states (IDLE, REQ, LOAD, READY)
//   slice_t       : slice index for the default 256-slice configuration
package spirose_pkg;

    localparam int SLICE_W = 8;

    typedef logic [SLICE_W-1:0] slice_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        LOAD  = 2'd2,
        READY = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/slice_scheduler_if.sv
// Position, fetch and display signals between the scheduler and its neighbours.
//   master : scheduler side (drives fetch request and display controls)
//   slave  : environment side (position block, framebuffer reader, LED driver)
interface slice_scheduler_if #(
    parameter int SLICE_COUNT = 256,
    parameter int SLICE_WIDTH = $clog2(SLICE_COUNT)
);
    // position stream
    logic                   position_sync;
    logic [SLICE_WIDTH-1:0] slice_cnt;
    // fetch handshake
    logic                   fetch_req;
    logic [SLICE_WIDTH-1:0] fetch_slice;
    logic                   fetch_buf;
    logic                   fetch_ack;
    logic                   fetch_done;
    // display control
    logic                   display_start;
    logic [SLICE_WIDTH-1:0] display_slice;
    logic                   display_buf;
    logic                   blank;

    modport master (
        input  position_sync, slice_cnt, fetch_ack, fetch_done,
        output fetch_req, fetch_slice, fetch_buf,
        output display_start, display_slice, display_buf, blank
    );

    modport slave (
        output position_sync, slice_cnt, fetch_ack, fetch_done,
        input  fetch_req, fetch_slice, fetch_buf,
        input  display_start, display_slice, display_buf, blank
    );
endinterface

// File: rtl/slice_watchdog.sv
// Rotation watchdog: counts cycles since the last position_sync.
//   position_sync in  : slice boundary pulse, clears the counter
//   rotation_ok   out : set by any sync, cleared once the count reaches STALL_TIMEOUT
//   stall         out : 1-cycle pulse in the cycle rotation is declared stopped
module slice_watchdog #(
    parameter int STALL_TIMEOUT = 5_000_000,
    parameter int TIMEOUT_WIDTH = 24
) (
    input  logic clk,
    input  logic nrst,
    input  logic position_sync,
    output logic rotation_ok,
    output logic stall
);
    localparam logic [TIMEOUT_WIDTH-1:0] TMO = TIMEOUT_WIDTH'(STALL_TIMEOUT);

    logic [TIMEOUT_WIDTH-1:0] cnt;

    // Only fires while rotation is still flagged, so it is a single pulse.
    assign stall = rotation_ok && !position_sync && (cnt == TMO);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt         <= '0;
            rotation_ok <= 1'b0;
        end else if (position_sync) begin
            cnt         <= '0;
            rotation_ok <= 1'b1;
        end else begin
            // Count holds at the timeout value rather than wrapping.
            if (cnt != TMO)
                cnt <= cnt + TIMEOUT_WIDTH'(1);
            if (stall)
                rotation_ok <= 1'b0;
        end
    end
endmodule

// File: rtl/slice_scheduler.sv
// Ping-pong slice scheduler between the hall-sensor position block and the
// framebuffer reader / LED driver.
//   clk, nrst   : clock, async active-low reset
//   bus         : position stream in, fetch handshake out, display control out
//   rotation_ok : rotation present (watchdog not expired)
//   overrun_cnt : saturating count of missed slices
module slice_scheduler
    import spirose_pkg::*;
#(
    parameter int SLICE_COUNT   = 256,
    parameter int SLICE_WIDTH   = $clog2(SLICE_COUNT),
    parameter int STALL_TIMEOUT = 5_000_000,
    parameter int TIMEOUT_WIDTH = 24,
    parameter int OVR_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 nrst,
    slice_scheduler_if.master    bus,
    output logic                 rotation_ok,
    output logic [OVR_WIDTH-1:0] overrun_cnt
);
    fetch_state_e           state, state_d;
    logic [SLICE_WIDTH-1:0] fslice, fslice_d;
    logic [SLICE_WIDTH-1:0] pslice, pslice_d;
    logic [SLICE_WIDTH-1:0] pend_slice, pend_slice_d;
    logic [SLICE_WIDTH-1:0] nxt;
    logic                   fbuf, fbuf_d;
    logic                   pvalid, pvalid_d;
    logic                   pend, pend_d;
    logic                   done_ev, hit, stall;
    logic                   disp_start, disp_buf, blank_q;
    logic [SLICE_WIDTH-1:0] disp_slice;

    slice_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_wdog (
        .clk           (clk),
        .nrst          (nrst),
        .position_sync (bus.position_sync),
        .rotation_ok   (rotation_ok),
        .stall         (stall)
    );

    // Power-of-two slice count: natural overflow gives the wrap to 0.
    assign nxt     = bus.slice_cnt + SLICE_WIDTH'(1);
    assign done_ev = (state == LOAD) && bus.fetch_done;

    // A load completing in the sync cycle counts, unless it is already stale.
    assign hit = bus.position_sync && rotation_ok &&
                 ((state == READY && pvalid && pslice == bus.slice_cnt) ||
                  (done_ev && !pend && fslice == bus.slice_cnt));

    always_comb begin
        state_d      = state;
        fslice_d     = fslice;
        fbuf_d       = fbuf;
        pvalid_d     = pvalid;
        pslice_d     = pslice;
        pend_d       = pend;
        pend_slice_d = pend_slice;

        unique case (state)
            IDLE: ;
            REQ: begin
                if (bus.fetch_ack)
                    state_d = LOAD;
            end
            LOAD: begin
                if (bus.fetch_done) begin
                    pend_d = 1'b0;
                    if (!rotation_ok) begin
                        state_d  = IDLE;
                        pvalid_d = 1'b0;
                    end else if (pend) begin
                        state_d  = REQ;
                        fslice_d = pend_slice;
                    end else begin
                        state_d  = READY;
                        pvalid_d = 1'b1;
                        pslice_d = fslice;
                    end
                end
            end
            READY: begin
                if (!rotation_ok) begin
                    state_d  = IDLE;
                    pvalid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Slice boundary overrides the idle progress above.
        if (bus.position_sync) begin
            if (hit) begin
                state_d  = REQ;
                fbuf_d   = ~fbuf;
                fslice_d = nxt;
                pvalid_d = 1'b0;
                pend_d   = 1'b0;
            end else begin
                case (state)
                    REQ: begin
                        // Once acked the request is committed; defer the retarget.
                        if (bus.fetch_ack) begin
                            pend_d       = 1'b1;
                            pend_slice_d = nxt;
                        end else begin
                            fslice_d = nxt;
                        end
                    end
                    LOAD: begin
                        if (bus.fetch_done) begin
                            state_d  = REQ;
                            fslice_d = nxt;
                            pend_d   = 1'b0;
                            pvalid_d = 1'b0;
                        end else begin
                            pend_d       = 1'b1;
                            pend_slice_d = nxt;
                        end
                    end
                    default: begin
                        state_d  = REQ;
                        fslice_d = nxt;
                        pvalid_d = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            fslice      <= '0;
            fbuf        <= 1'b0;
            pvalid      <= 1'b0;
            pslice      <= '0;
            pend        <= 1'b0;
            pend_slice  <= '0;
            disp_start  <= 1'b0;
            disp_slice  <= '0;
            disp_buf    <= 1'b0;
            blank_q     <= 1'b1;
            overrun_cnt <= '0;
        end else begin
            state      <= state_d;
            fslice     <= fslice_d;
            fbuf       <= fbuf_d;
            pvalid     <= pvalid_d;
            pslice     <= pslice_d;
            pend       <= pend_d;
            pend_slice <= pend_slice_d;
            disp_start <= hit;
            if (hit) begin
                disp_slice <= bus.slice_cnt;
                disp_buf   <= fbuf;
                blank_q    <= 1'b0;
            end else if (bus.position_sync || stall) begin
                blank_q <= 1'b1;
            end
            // The sync that ends a stall is a miss but not an overrun.
            if (bus.position_sync && !hit && rotation_ok && overrun_cnt != '1)
                overrun_cnt <= overrun_cnt + OVR_WIDTH'(1);
        end
    end

    assign bus.fetch_req     = (state == REQ);
    assign bus.fetch_slice   = fslice;
    assign bus.fetch_buf     = fbuf;
    assign bus.display_start = disp_start;
    assign bus.display_slice = disp_slice;
    assign bus.display_buf   = disp_buf;
    assign bus.blank         = blank_q;
endmodule
